// File: rtl/ay_stereo_dac.sv
// Stereo mixer for two AY chips plus beeper/tape, with per-side first-order
// sigma-delta DACs. Pipeline: S1 per-chip side sums, S2 final mix, S3 modulator.
`timescale 1ns/1ps
module ay_stereo_dac (
  input  logic        clk28,
  input  logic        rst_n,
  input  logic        en_ts,
  input  logic        mute,
  input  logic [1:0]  stereo_mode,
  input  logic [7:0]  ay_a0,
  input  logic [7:0]  ay_b0,
  input  logic [7:0]  ay_c0,
  input  logic [7:0]  ay_a1,
  input  logic [7:0]  ay_b1,
  input  logic [7:0]  ay_c1,
  input  logic        beeper,
  input  logic        tape_out,
  input  logic        tape_in,
  output logic [10:0] mix_l,
  output logic [10:0] mix_r,
  output logic        dac_l,
  output logic        dac_r
);

  localparam logic [1:0] MODE_MONO = 2'd0;
  localparam logic [1:0] MODE_ACB  = 2'd2;
  localparam logic [1:0] MODE_BAC  = 2'd3;

  logic [7:0]  ch_a [2];
  logic [7:0]  ch_b [2];
  logic [7:0]  ch_c [2];
  logic [9:0]  chip_l [2];
  logic [9:0]  chip_r [2];
  logic [10:0] mix_side [2];
  logic        dac_side [2];

  assign ch_a[0] = ay_a0;
  assign ch_b[0] = ay_b0;
  assign ch_c[0] = ay_c0;
  assign ch_a[1] = ay_a1;
  assign ch_b[1] = ay_b1;
  assign ch_c[1] = ay_c1;

  // S1 control snapshot: every S2 result is built from one cycle's controls.
  logic [1:0] mode_reg;
  logic       en_ts_reg;
  logic       mute_reg;
  logic       beeper_reg;
  logic       tape_out_reg;
  logic       tape_in_reg;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg     <= MODE_MONO;
      en_ts_reg    <= 1'b0;
      mute_reg     <= 1'b0;
      beeper_reg   <= 1'b0;
      tape_out_reg <= 1'b0;
      tape_in_reg  <= 1'b0;
    end else begin
      mode_reg     <= stereo_mode;
      en_ts_reg    <= en_ts;
      mute_reg     <= mute;
      beeper_reg   <= beeper;
      tape_out_reg <= tape_out;
      tape_in_reg  <= tape_in;
    end
  end

  genvar gi;

  // S1: per-chip side sums. X/Y/Z are left, centre and right channels.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chip
      logic [7:0] x_sel;
      logic [7:0] y_sel;
      logic [7:0] z_sel;
      logic [9:0] l_next;
      logic [9:0] r_next;
      logic [9:0] l_reg;
      logic [9:0] r_reg;

      always_comb begin
        x_sel = ch_a[gi];
        y_sel = ch_b[gi];
        z_sel = ch_c[gi];
        case (stereo_mode)
          MODE_ACB: begin
            y_sel = ch_c[gi];
            z_sel = ch_b[gi];
          end
          MODE_BAC: begin
            x_sel = ch_b[gi];
            y_sel = ch_a[gi];
          end
          default: ;
        endcase
        if (stereo_mode == MODE_MONO) begin
          l_next = {2'b00, ch_a[gi]} + {2'b00, ch_b[gi]} + {2'b00, ch_c[gi]};
          r_next = l_next;
        end else begin
          l_next = {1'b0, x_sel, 1'b0} + {2'b00, y_sel};
          r_next = {1'b0, z_sel, 1'b0} + {2'b00, y_sel};
        end
      end

      always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
          l_reg <= '0;
          r_reg <= '0;
        end else begin
          l_reg <= l_next;
          r_reg <= r_next;
        end
      end

      assign chip_l[gi] = l_reg;
      assign chip_r[gi] = r_reg;
    end
  endgenerate

  // S2 and S3 per side (gi = 0 left, 1 right); the two sides share nothing
  // but the control snapshot.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_side
      logic [9:0]  c0_sum;
      logic [9:0]  c1_sum;
      logic [10:0] src_sum;
      logic [10:0] mix_next;
      logic [10:0] mix_reg;
      logic [11:0] acc_next;
      logic [11:0] acc_reg;

      always_comb begin
        if (gi == 0 || mode_reg == MODE_MONO) begin
          c0_sum = chip_l[0];
          c1_sum = chip_l[1];
        end else begin
          c0_sum = chip_r[0];
          c1_sum = chip_r[1];
        end
        if (!en_ts_reg) begin
          c1_sum = '0;
        end
        // beeper weighs 256, tape_out 64, tape_in 32
        src_sum  = {2'b00, beeper_reg, 1'b0, tape_out_reg, tape_in_reg, 5'b00000};
        mix_next = mute_reg ? 11'd0
                            : {1'b0, c0_sum} + {1'b0, c1_sum} + src_sum;
        acc_next = {1'b0, acc_reg[10:0]} + {1'b0, mix_reg};
      end

      // acc_reg[11] is the carry of the latest update, so it is the DAC bit.
      always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
          mix_reg <= '0;
          acc_reg <= '0;
        end else begin
          mix_reg <= mix_next;
          acc_reg <= acc_next;
        end
      end

      assign mix_side[gi] = mix_reg;
      assign dac_side[gi] = acc_reg[11];
    end
  endgenerate

  assign mix_l = mix_side[0];
  assign mix_r = mix_side[1];
  assign dac_l = dac_side[0];
  assign dac_r = dac_side[1];

endmodule
